execute_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, downstream of the decode→execute pipeline register. It consumes the operands and M-extension op that register delivers, and computes the result over multiple cycles. It holds the front of the pipeline via a stall request until the result is ready, then presents it for one cycle for capture by the execute→memory register. It is killed by branch-mispredict flush.

---
 rtl/execute_muldiv_pkg.sv | 34 +++
 rtl/execute_muldiv.sv | 136 +++++++++++++
 tb/tb_execute_muldiv.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package execute_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic src1_signed(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic src2_signed(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps on operand magnitudes,
// then a sign-fix cycle; div-by-zero and signed overflow resolve immediately.
//
// state | meaning
// IDLE  | waiting for start_i; latches operands or resolves a special case
// CALC  | one shift-add / restoring shift-subtract step per cycle
// FIX   | apply signs, select result word into result_o
// DONE  | result_o valid (done_o), pipeline released
module execute_muldiv
    import execute_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    md_state_e   state;
    md_op_e      op_q;
    logic [31:0] opb_q;
    logic [63:0] acc_q;
    logic        neg1_q, neg2_q;
    logic [5:0]  cnt_q;

    md_op_e      op_in;
    logic        neg1, neg2, div_in, div_zero, div_ovf;
    logic [31:0] mag1, mag2, special_res;

    assign op_in    = md_op_e'(op_i);
    assign div_in   = is_div(op_in);
    assign neg1     = src1_signed(op_in) && src1_i[31];
    assign neg2     = src2_signed(op_in) && src2_i[31];
    assign mag1     = neg1 ? -src1_i : src1_i;
    assign mag2     = neg2 ? -src2_i : src2_i;
    assign div_zero = div_in && (src2_i == 32'd0);
    assign div_ovf  = (op_in == MD_DIV || op_in == MD_REM) &&
                      (src1_i == 32'h8000_0000) && (src2_i == 32'hFFFF_FFFF);

    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = (op_in == MD_DIV || op_in == MD_DIVU) ? 32'hFFFF_FFFF : src1_i;
        else if (div_ovf)
            special_res = (op_in == MD_DIV) ? 32'h8000_0000 : 32'd0;
    end

    // Multiply: multiplier sits in acc_q[31:0] and shifts out as the product shifts in.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

    // Divide: partial remainder in acc_q[63:32], dividend/quotient bits below.
    logic [32:0] rem_top;
    logic        div_ok;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    assign rem_top  = acc_q[63:31];
    assign div_ok   = rem_top >= {1'b0, opb_q};
    assign div_rem  = rem_top[31:0] - opb_q;
    assign div_next = div_ok ? {div_rem, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    logic [63:0] prod_s;
    logic [31:0] fix_res;
    assign prod_s = (neg1_q ^ neg2_q) ? -acc_q : acc_q;

    always_comb begin
        fix_res = 32'd0;
        case (op_q)
            MD_MUL:                        fix_res = prod_s[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = prod_s[63:32];
            MD_DIV, MD_DIVU:               fix_res = (neg1_q ^ neg2_q) ? -acc_q[31:0] : acc_q[31:0];
            MD_REM, MD_REMU:               fix_res = neg1_q ? -acc_q[63:32] : acc_q[63:32];
            default:                       fix_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= MD_MUL;
            opb_q    <= 32'd0;
            acc_q    <= 64'd0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            cnt_q    <= 6'd0;
            done_o   <= 1'b0;
            result_o <= 32'd0;
        end else if (flush_i) begin
            state  <= ST_IDLE;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: if (start_i) begin
                    op_q   <= op_in;
                    neg1_q <= neg1;
                    neg2_q <= neg2;
                    cnt_q  <= 6'd0;
                    opb_q  <= div_in ? mag2 : mag1;
                    acc_q  <= {32'd0, div_in ? mag1 : mag2};
                    if (div_zero || div_ovf) begin
                        result_o <= special_res;
                        done_o   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= is_div(op_q) ? div_next : mul_next;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result_o <= fix_res;
                    done_o   <= 1'b1;
                    state    <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = (state == ST_CALC) || (state == ST_FIX);
    assign stall_o = ((state == ST_IDLE) && start_i && !flush_i) || busy_o;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: hand-computed results, latency, stall,
// flush, reset and back-to-back behaviour.
module tb_execute_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;

    execute_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one op in the next cycle, scramble inputs after edge 0, wait for done_o.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        int cyc;
        int n_stall;
        @(negedge clk);
        check({tag, " done_before"}, {31'd0, done_o}, 32'd0);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
        #1;
        n_stall = stall_o ? 1 : 0;
        @(negedge clk);
        start_i = 1'b0; op_i = ~op; src1_i = ~a; src2_i = ~b;
        cyc = 1;
        while (!done_o && cyc < 60) begin
            if (stall_o) n_stall++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " result"}, result_o, exp);
        check({tag, " stall_in_done"}, {31'd0, stall_o}, 32'd0);
        check({tag, " stall_cycles"}, n_stall, lat);
    endtask

    initial begin
        int n_done;
        int first_done;
        logic prev_done;
        logic twin;

        rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; op_i = 3'd0; src1_i = 32'd0; src2_i = 32'd0;
        repeat (3) @(negedge clk);
        check("rst result", result_o, 32'd0);
        check("rst done", {31'd0, done_o}, 32'd0);
        check("rst busy", {31'd0, busy_o}, 32'd0);
        check("rst stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "MULH");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "MULHSU");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "DIV");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "REM");
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        34, "DIVU");
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         34, "REMU");
        run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "DIVU0");
        run_op(3'd7, 32'd5,         32'd0,         32'd5,         1,  "REMU0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIVOVF");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "REMOVF");
        run_op(3'd4, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1,  "DIV0");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,  "REM0");

        // Flush a DIV during cycle 10.
        @(negedge clk);
        op_i = 3'd4; src1_i = 32'd1000; src2_i = 32'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush busy", {31'd0, busy_o}, 32'd0);
        check("flush stall", {31'd0, stall_o}, 32'd0);
        check("flush done", {31'd0, done_o}, 32'd0);
        check("flush result_kept", result_o, 32'hFFFF_FFF9);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) n_done++;
            @(negedge clk);
        end
        check("flush no_done", n_done, 0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "MUL_after_flush");

        // start_i held through DONE: ops at cycles 0 and 35, done at 34 and 69.
        @(negedge clk);
        op_i = 3'd0; src1_i = 32'd3; src2_i = 32'd5; start_i = 1'b1;
        n_done = 0; first_done = -1; prev_done = 1'b0; twin = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (c == 36) start_i = 1'b0;
            if (done_o) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (done_o && prev_done) twin = 1'b1;
            prev_done = done_o;
            @(negedge clk);
        end
        check("held done_count", n_done, 2);
        check("held first_done", first_done, 34);
        check("held single_pulse", {31'd0, twin}, 32'd0);
        check("held result", result_o, 32'd15);

        // Back-to-back with only the one IDLE cycle between.
        run_op(3'd0, 32'd6,         32'd7,         32'd42,        34, "B2B_1");
        run_op(3'd0, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 34, "B2B_2");

        // Reset at cycle 20 of a MUL.
        @(negedge clk);
        op_i = 3'd0; src1_i = 32'd9; src2_i = 32'd9; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst result", result_o, 32'd0);
        check("midrst done", {31'd0, done_o}, 32'd0);
        check("midrst busy", {31'd0, busy_o}, 32'd0);
        check("midrst stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;
        run_op(3'd0, 32'd9, 32'd9, 32'd81, 34, "MUL_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
